keypad_scanner_param: RTL and testbench

KEYPAD_SCANNER_PARAM -- requirements
Module: keypad_scanner_param

---
 rtl/keypad_scanner_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_keypad_scanner_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_param.sv
// Row-scanning matrix keypad controller.
// Drives one row low at a time, samples the active-low columns after a settle
// delay, debounces press and release, and optionally auto-repeats a held key.
// Every output is a register; the next-state logic is purely combinational.
module keypad_scanner_param #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 5000,
  parameter int unsigned REPEAT_RATE     = 1000,
  localparam int unsigned KeyW           = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_matriz,
  output logic [ROWS-1:0] lin_matriz,
  output logic [KeyW-1:0] tecla_value,
  output logic            tecla_valid,
  output logic            tecla_held,
  output logic            multi_key
);

  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned MaxSd = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                    : DEBOUNCE_CYCLES;
  localparam int unsigned MaxRp = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned MaxCnt = (MaxSd > MaxRp) ? MaxSd : MaxRp;
  localparam int unsigned CntW  = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] DebCnt     = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] DelayCnt   = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] RateCnt    = CntW'(REPEAT_RATE);
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
  localparam logic [RowW-1:0] RowLast    = RowW'(ROWS - 1);
  localparam logic [ROWS-1:0] LinReset   = {{(ROWS - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StHeld,
    StReleaseDb
  } state_e;

  state_e state_q, state_d;

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [COLS-1:0] pat_q, pat_d;
  // One counter serves settle, debounce and repeat timing; only one is live per state.
  logic [CntW-1:0] cnt_q, cnt_d;
  // Set while waiting for the first repeat (REPEAT_DELAY), cleared for REPEAT_RATE spacing.
  logic            first_q, first_d;
  logic [ROWS-1:0] lin_q, lin_d;
  logic [KeyW-1:0] value_q, value_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            multi_q, multi_d;

  logic            any_low, multi_low;
  logic [ColW-1:0] low_idx;
  logic            col_all_ones, col_match;
  logic            settle_done, deb_done, rep_hit;
  logic [CntW-1:0] cnt_inc, rep_target;
  logic [RowW-1:0] row_next;
  logic [KeyW-1:0] key_idx;

  // Classify the sampled column pattern: none, exactly one, or several keys low.
  always_comb begin
    any_low   = 1'b0;
    multi_low = 1'b0;
    low_idx   = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_matriz[c]) begin
        if (any_low) begin
          multi_low = 1'b1;
        end
        any_low = 1'b1;
        low_idx = ColW'(c);
      end
    end
  end

  assign col_all_ones = &col_matriz;
  assign col_match    = (col_matriz == pat_q);
  assign cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign settle_done  = (cnt_q >= SettleLast);
  assign deb_done     = (cnt_inc >= DebCnt);
  assign rep_target   = first_q ? DelayCnt : RateCnt;
  assign rep_hit      = REPEAT_EN && (cnt_inc >= rep_target);
  assign row_next     = (row_q == RowLast) ? '0 : row_q + 1'b1;
  assign key_idx      = KeyW'(32'(row_q) * COLS + 32'(col_q));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StScan: begin
        if (settle_done && any_low && !multi_low) begin
          state_d = StPressDb;
        end
      end
      StPressDb: begin
        if (!col_match) begin
          state_d = StScan;
        end else if (deb_done) begin
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (!col_match) begin
          state_d = StReleaseDb;
        end
      end
      StReleaseDb: begin
        if (col_all_ones && deb_done) begin
          state_d = StScan;
        end else if (col_match) begin
          state_d = StHeld;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    value_d = value_q;
    held_d  = held_q;
    valid_d = 1'b0;
    multi_d = 1'b0;
    unique case (state_q)
      StScan: begin
        if (settle_done) begin
          cnt_d = '0;
          if (!any_low) begin
            row_d = row_next;
          end else if (multi_low) begin
            multi_d = 1'b1;
            row_d   = row_next;
          end else begin
            // Row stays driven so the debounce watches the same key.
            col_d = low_idx;
            pat_d = col_matriz;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressDb: begin
        if (!col_match) begin
          cnt_d = '0;
        end else if (deb_done) begin
          cnt_d   = '0;
          value_d = key_idx;
          valid_d = 1'b1;
          held_d  = 1'b1;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeld: begin
        if (!col_match) begin
          cnt_d = '0;
        end else if (rep_hit) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StReleaseDb: begin
        if (col_all_ones) begin
          if (deb_done) begin
            cnt_d  = '0;
            held_d = 1'b0;
            row_d  = row_next;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Either the key bounced back (return to hold) or noise: restart either way.
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    lin_d = ~(ROWS'(1) << row_d);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q   <= '0;
      col_q   <= '0;
      pat_q   <= '1;
      cnt_q   <= '0;
      first_q <= 1'b1;
      lin_q   <= LinReset;
      value_q <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      lin_q   <= lin_d;
      value_q <= value_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  assign lin_matriz  = lin_q;
  assign tecla_value = value_q;
  assign tecla_valid = valid_q;
  assign tecla_held  = held_q;
  assign multi_key   = multi_q;

  // Exactly one row is driven low at any time.
  a_lin_one_cold: assert property (@(posedge clk) disable iff (!rst) $onehot(~lin_matriz));
  // A key event is only reported while the key counts as held.
  a_valid_held: assert property (@(posedge clk) disable iff (!rst) tecla_valid |-> tecla_held);

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench for keypad_scanner_param: two instances (auto-repeat off / on) share one
// reset and one pressed-key map; a keypad model turns each DUT's row drive into
// its column sense. Expected pulses are queued per DUT and checked by a monitor.
module tb_keypad_scanner_param;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     pressed;
  logic [COLS-1:0] col0, col1;
  logic [ROWS-1:0] lin0, lin1;
  logic [3:0]      val0, val1;
  logic            vld0, vld1, held0, held1, mk0, mk1;

  int cyc;
  int n_tests;
  int n_fail;

  typedef struct {
    bit         is_multi;
    logic [3:0] value;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  keypad_scanner_param #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_dut0 (
    .clk(clk), .rst(rst), .col_matriz(col0), .lin_matriz(lin0), .tecla_value(val0),
    .tecla_valid(vld0), .tecla_held(held0), .multi_key(mk0)
  );

  keypad_scanner_param #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .col_matriz(col1), .lin_matriz(lin1), .tecla_value(val1),
    .tecla_valid(vld1), .tecla_held(held1), .multi_key(mk1)
  );

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col0 = '1;
    col1 = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (pressed[r * COLS + c]) begin
          if (!lin0[r]) col0[c] = 1'b0;
          if (!lin1[r]) col1[c] = 1'b0;
        end
      end
    end
  end

  // Cycle number: rising edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
    end
  endtask

  task automatic expect_pulse(input int d, input bit m, input logic [3:0] v, input int c);
    exp_t e;
    e.is_multi = m;
    e.value    = v;
    e.cyc      = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_pulse(input int d, input bit m, input logic [3:0] v);
    exp_t e;
    n_tests++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_pulse dut%0d multi=%0d cyc=%0d got=pulse required=none",
               d, m, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.is_multi != m || e.cyc != cyc || (!m && e.value !== v)) begin
      n_fail++;
      $display("FAIL pulse dut%0d got multi=%0d key=%0d cyc=%0d required multi=%0d key=%0d cyc=%0d",
               d, m, v, cyc, e.is_multi, e.value, e.cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of that DUT's queue.
  always @(negedge clk) begin
    if (rst) begin
      if (vld0) mon_pulse(0, 1'b0, val0);
      if (mk0)  mon_pulse(0, 1'b1, 4'd0);
      if (vld1) mon_pulse(1, 1'b0, val1);
      if (mk1)  mon_pulse(1, 1'b1, 4'd0);
    end
  end

  task automatic chk_drained(input string name);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_pulses got=%0d/%0d pending required=0/0",
               name, q0.size(), q1.size());
    end
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL at_cyc got=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk);
    rst     = 1'b0;
    pressed = keys;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [3:0] idle_lin [5];

  initial begin
    rst      = 1'b0;
    pressed  = '0;
    n_tests  = 0;
    n_fail   = 0;
    idle_lin = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Idle scan: one row per cycle, no pulses.
    do_reset(16'h0000);
    chk("reset_value", 32'(val0), 32'h0);
    chk("reset_held", 32'(held0), 32'h0);
    for (int k = 0; k <= 4; k++) begin
      at_cyc(k);
      chk("idle_lin", 32'(lin0), 32'(idle_lin[k]));
    end
    chk("idle_lin_rep", 32'(lin1), 32'he);
    at_cyc(10);
    chk_drained("idle");

    // Key 9 (row 2, col 1): detected at edge 3, accepted at cycle 7.
    do_reset(16'h0200);
    expect_pulse(0, 1'b0, 4'd9, 7);
    expect_pulse(1, 1'b0, 4'd9, 7);
    at_cyc(6);
    chk("press_held_early", 32'(held0), 32'h0);
    at_cyc(7);
    chk("press_held", 32'(held0), 32'h1);
    chk("press_value", 32'(val0), 32'h9);
    at_cyc(12);
    pressed = '0;
    at_cyc(16);
    chk("release_held_still", 32'(held0), 32'h1);
    at_cyc(17);
    chk("release_held_clr", 32'(held0), 32'h0);
    chk("release_held_clr_rep", 32'(held1), 32'h0);
    chk("release_lin", 32'(lin0), 32'h7);
    chk("release_value_kept", 32'(val0), 32'h9);
    at_cyc(22);
    chk_drained("press9");

    // Key 3 bounce too short: no accept, scanning resumes on row 0.
    do_reset(16'h0008);
    at_cyc(2);
    chk("bounce_lin_hold", 32'(lin0), 32'he);
    at_cyc(3);
    pressed = '0;
    at_cyc(4);
    chk("bounce_lin_resume", 32'(lin0), 32'he);
    at_cyc(5);
    chk("bounce_lin_next", 32'(lin0), 32'hd);
    at_cyc(12);
    chk("bounce_held", 32'(held0), 32'h0);
    chk_drained("bounce");

    // Keys 4 and 6 together on row 1: multi_key pulse, row advances.
    do_reset(16'h0050);
    expect_pulse(0, 1'b1, 4'd0, 2);
    expect_pulse(1, 1'b1, 4'd0, 2);
    at_cyc(2);
    chk("multi_lin", 32'(lin0), 32'hb);
    at_cyc(3);
    pressed = '0;
    at_cyc(10);
    chk("multi_held", 32'(held0), 32'h0);
    chk_drained("multi");

    // Key 5 held: accept at 6, repeats at 16, 19, 22; one-cycle glitch adds nothing.
    do_reset(16'h0020);
    expect_pulse(0, 1'b0, 4'd5, 6);
    expect_pulse(1, 1'b0, 4'd5, 6);
    expect_pulse(1, 1'b0, 4'd5, 16);
    expect_pulse(1, 1'b0, 4'd5, 19);
    expect_pulse(1, 1'b0, 4'd5, 22);
    at_cyc(23);
    pressed = '0;
    at_cyc(24);
    pressed = 16'h0020;
    chk("glitch_held", 32'(held1), 32'h1);
    at_cyc(26);
    pressed = '0;
    at_cyc(30);
    chk("repeat_held_still", 32'(held1), 32'h1);
    at_cyc(31);
    chk("repeat_held_clr", 32'(held1), 32'h0);
    chk("repeat_lin", 32'(lin1), 32'hb);
    chk("repeat_value", 32'(val1), 32'h5);
    at_cyc(36);
    chk_drained("repeat");

    // Reset mid-hold, then mid-debounce: outputs clear at once, key is discarded.
    do_reset(16'h0200);
    expect_pulse(0, 1'b0, 4'd9, 7);
    expect_pulse(1, 1'b0, 4'd9, 7);
    at_cyc(9);
    chk("prehold_value", 32'(val0), 32'h9);
    rst = 1'b0;
    #1;
    chk("rst_hold_value", 32'(val0), 32'h0);
    chk("rst_hold_held", 32'(held0), 32'h0);
    chk("rst_hold_lin", 32'(lin0), 32'he);
    chk("rst_hold_value_rep", 32'(val1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    expect_pulse(0, 1'b0, 4'd9, 7);
    expect_pulse(1, 1'b0, 4'd9, 7);
    at_cyc(7);
    at_cyc(8);
    chk_drained("reaccept");
    pressed = '0;
    at_cyc(15);
    do_reset(16'h0200);
    at_cyc(5);
    chk("predb_lin", 32'(lin0), 32'hb);
    rst = 1'b0;
    #1;
    chk("rst_db_lin", 32'(lin0), 32'he);
    chk("rst_db_valid", 32'(vld0), 32'h0);
    chk("rst_db_held", 32'(held0), 32'h0);
    chk("rst_db_multi", 32'(mk0), 32'h0);
    pressed = '0;
    @(negedge clk);
    rst = 1'b1;
    at_cyc(15);
    chk("rst_db_no_key", 32'(held0), 32'h0);
    chk_drained("rst_db");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
